// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory-side model:
// FSM state encoding, stall counter width, LFSR constants and the
// byte-strobe merge helper used by the RAM write path.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Wait states are limited to 0..15.
    localparam int STALL_W = 4;

    // Galois LFSR, taps 16,14,13,11 (right-shifting form).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MERGE_W = 512;

    // Replace the bytes of old_w selected by strb with the bytes of new_w.
    function automatic logic [MERGE_W-1:0] strb_merge(
        input logic [MERGE_W-1:0]   old_w,
        input logic [MERGE_W-1:0]   new_w,
        input logic [MERGE_W/8-1:0] strb
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int b = 0; b < MERGE_W / 8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port byte-strobed RAM with a registered read port. Kept as its
// own module so a technology macro can be dropped in. Read-first: a write
// cycle returns the previous word contents. Contents are never reset.
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_en,
    input  logic                      i_we,
    input  logic [$clog2(DEPTH)-1:0]  i_idx,
    input  logic [DATA_W/8-1:0]       i_strb,
    input  logic [DATA_W-1:0]         i_wdata,
    output logic [DATA_W-1:0]         o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Registered read and byte-merged write of the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_idx];
            if (i_we) begin
                r_mem[i_idx] <= DATA_W'(strb_merge(MERGE_W'(r_mem[i_idx]),
                                                   MERGE_W'(i_wdata),
                                                   (MERGE_W/8)'(i_strb)));
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for a req/gnt initiator. Decodes the byte address
// into a word of the local RAM, inserts wait states, then pulses gnt with
// rdata/err for one cycle. Flags initiator protocol violations (req drop
// or request change while waiting) in a sticky proto_err.
// Optional build macro MEM_RESPONDER_RANDOM_STALL_EN: per-request stall
// drawn from a free-running LFSR, clamped to STALL_CYCLES.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                    MEM_ADDR_W   = 64,
    parameter int                    MEM_DATA_W   = 64,
    parameter int                    DEPTH_WORDS  = 1024,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR    = 64'h0,
    parameter int                    STALL_CYCLES = 0,
    parameter logic [MEM_ADDR_W-1:0] ERR_ADDR     = 64'hFFFF_FFFF_FFFF_FFF8
) (
    input  logic                    g_clk,
    input  logic                    g_reset,
    input  logic                    mem_req,
    input  logic [MEM_ADDR_W-1:0]   mem_addr,
    input  logic                    mem_wen,
    input  logic [MEM_DATA_W/8-1:0] mem_strb,
    input  logic [MEM_DATA_W-1:0]   mem_wdata,
    output logic                    mem_gnt,
    output logic                    mem_err,
    output logic [MEM_DATA_W-1:0]   mem_rdata,
    output logic                    proto_err
);

    localparam int STRB_W = MEM_DATA_W / 8;
    localparam int OFS_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [MEM_ADDR_W-1:0] SPAN      = MEM_ADDR_W'(DEPTH_WORDS * STRB_W);
    localparam logic [MEM_ADDR_W-1:0] WORD_MASK = ~(MEM_ADDR_W'(STRB_W - 1));
    localparam logic [STALL_W-1:0]    STALL_MAX = STALL_W'(STALL_CYCLES);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [STALL_W-1:0]      r_cnt;
    logic [MEM_ADDR_W-1:0]   r_addr;
    logic                    r_wen;
    logic [STRB_W-1:0]       r_strb;
    logic [MEM_DATA_W-1:0]   r_wdata;
    logic                    r_err;
    logic                    r_proto_err;

    logic [STALL_W-1:0]      w_stall;
    logic                    w_abandon;
    logic                    w_mismatch;
    logic [MEM_ADDR_W-1:0]   w_sel_addr;
    logic                    w_sel_wen;
    logic [STRB_W-1:0]       w_sel_strb;
    logic [MEM_DATA_W-1:0]   w_sel_wdata;
    logic [MEM_ADDR_W-1:0]   w_offset;
    logic                    w_err;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_ram_en;
    logic [MEM_DATA_W-1:0]   w_ram_rdata;

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running LFSR; its low nibble picks the stall of each accepted request.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0);
        end
    end

    assign w_stall = (r_lfsr[STALL_W-1:0] > STALL_MAX) ? STALL_MAX : r_lfsr[STALL_W-1:0];
`else
    assign w_stall = STALL_MAX;
`endif

    // In IDLE the live request goes straight to the RAM (zero-stall case);
    // once waiting, the captured copy is authoritative.
    assign w_sel_addr  = (r_state == ST_IDLE) ? mem_addr  : r_addr;
    assign w_sel_wen   = (r_state == ST_IDLE) ? mem_wen   : r_wen;
    assign w_sel_strb  = (r_state == ST_IDLE) ? mem_strb  : r_strb;
    assign w_sel_wdata = (r_state == ST_IDLE) ? mem_wdata : r_wdata;

    assign w_offset = w_sel_addr - BASE_ADDR;
    assign w_idx    = IDX_W'(w_offset >> OFS_W);
    assign w_err    = (w_sel_addr < BASE_ADDR) || (w_offset >= SPAN) ||
                      ((w_sel_addr & WORD_MASK) == (ERR_ADDR & WORD_MASK));

    // RAM is touched only on entry to RESP; never while reset is held.
    assign w_ram_en = (w_state_next == ST_RESP) && !w_err && !g_reset;

    mem_responder_ram #(
        .DATA_W (MEM_DATA_W),
        .DEPTH  (DEPTH_WORDS)
    ) u_ram (
        .i_clk   (g_clk),
        .i_en    (w_ram_en),
        .i_we    (w_sel_wen),
        .i_idx   (w_idx),
        .i_strb  (w_sel_strb),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, protocol checks and response outputs.
    always_comb begin
        w_state_next = r_state;
        w_abandon    = 1'b0;
        w_mismatch   = 1'b0;
        mem_gnt      = 1'b0;
        mem_err      = 1'b0;
        mem_rdata    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_state_next = (w_stall == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mem_req) begin
                    w_abandon    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_mismatch = (mem_addr != r_addr) || (mem_wen != r_wen) ||
                                 (mem_strb != r_strb) || (mem_wdata != r_wdata);
                    if (r_cnt == STALL_W'(1)) begin
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                mem_gnt      = 1'b1;
                mem_err      = r_err;
                mem_rdata    = (r_err || r_wen) ? '0 : w_ram_rdata;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, stall countdown, response error and sticky proto_err.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_strb      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && mem_req) begin
                r_addr  <= mem_addr;
                r_wen   <= mem_wen;
                r_strb  <= mem_strb;
                r_wdata <= mem_wdata;
                r_cnt   <= w_stall;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - STALL_W'(1);
            end
            if (w_state_next == ST_RESP) begin
                r_err <= w_err;
            end
            if (w_abandon || w_mismatch) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with stalls 0, 3 and 5 share
// a clock and reset. Directed table, randomized traffic against a word
// array model, and hand-written latency / abandon / change / reset cases.
module tb_mem_responder;

    localparam int          NDUT = 3;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ERRA = BASE + 64'h100;
    localparam logic [63:0] SPAN = 64'd8192;
    localparam int          RGN  = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [NDUT-1:0] req, wen, gnt, err, perr;
    logic [63:0]     addr  [NDUT];
    logic [7:0]      strb  [NDUT];
    logic [63:0]     wdata [NDUT];
    logic [63:0]     rdata [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mdl [2][16];

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [7:0]  s;
        logic [63:0] wd;
        logic        e;
        logic [63:0] rd;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        mem_responder #(
            .BASE_ADDR    (BASE),
            .ERR_ADDR     (ERRA),
            .STALL_CYCLES ((gi == 0) ? 0 : ((gi == 1) ? 3 : 5))
        ) u_dut (
            .g_clk     (clk),
            .g_reset   (rst),
            .mem_req   (req[gi]),
            .mem_addr  (addr[gi]),
            .mem_wen   (wen[gi]),
            .mem_strb  (strb[gi]),
            .mem_wdata (wdata[gi]),
            .mem_gnt   (gnt[gi]),
            .mem_err   (err[gi]),
            .mem_rdata (rdata[gi]),
            .proto_err (perr[gi])
        );
    end

    function automatic int stall_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    // Error rule straight from the address map.
    function automatic logic ref_err(input logic [63:0] a);
        return (a < BASE) || (a >= BASE + SPAN) || ((a >> 3) == (ERRA >> 3));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] wd, output int lat, output logic e, output logic [63:0] rd);
        @(negedge clk);
        req[d] = 1'b1; wen[d] = w; addr[d] = a; strb[d] = s; wdata[d] = wd;
        lat = 0; e = 1'bx; rd = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (gnt[d]) begin
                lat = k; e = err[d]; rd = rdata[d];
                break;
            end
        end
        req[d] = 1'b0;
        $display("txn dut%0d %s addr=%h strb=%h wdata=%h -> lat=%0d err=%b rdata=%h",
                 d, w ? "WR" : "RD", a, s, wd, lat, e, rd);
    endtask

    task automatic run_chk(input string nm, input int d, input logic w, input logic [63:0] a,
                           input logic [7:0] s, input logic [63:0] wd,
                           input logic exp_e, input logic [63:0] exp_rd);
        int          lat;
        logic        e;
        logic [63:0] rd;
        txn(d, w, a, s, wd, lat, e, rd);
        check({nm, " latency"}, 64'(lat), 64'(1 + stall_of(d)));
        check({nm, " err"}, 64'(e), 64'(exp_e));
        check({nm, " rdata"}, rd, exp_rd);
    endtask

    initial begin
        logic [7:0]  pat;
        logic [63:0] a, wd, rd_cap;
        logic        w, e;
        logic [7:0]  s;
        int          idx;

        req = '0; wen = '0;
        for (int i = 0; i < NDUT; i++) begin
            addr[i] = '0; strb[i] = '0; wdata[i] = '0;
        end

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset gnt dut%0d", i), 64'(gnt[i]), 64'd0);
            check($sformatf("reset err dut%0d", i), 64'(err[i]), 64'd0);
            check($sformatf("reset rdata dut%0d", i), rdata[i], 64'd0);
            check($sformatf("reset proto_err dut%0d", i), 64'(perr[i]), 64'd0);
        end
        rst = 1'b0;

        // Directed table on the zero-stall instance
        tbl[0]  = '{1'b1, BASE + 64'h8,    8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, BASE + 64'h8,    8'h00, 64'h0, 1'b0, 64'h1122334455667788};
        tbl[2]  = '{1'b1, BASE + 64'h8,    8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 64'h0};
        tbl[3]  = '{1'b0, BASE + 64'h8,    8'h00, 64'h0, 1'b0, 64'h11223344_BBBBBBBB};
        tbl[4]  = '{1'b0, BASE + 64'hF,    8'h00, 64'h0, 1'b0, 64'h11223344_BBBBBBBB};
        tbl[5]  = '{1'b1, BASE,            8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'h0};
        tbl[6]  = '{1'b1, BASE + 64'h1FF8, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0};
        tbl[7]  = '{1'b0, ERRA,            8'h00, 64'h0, 1'b1, 64'h0};
        tbl[8]  = '{1'b1, ERRA + 64'h4,    8'hFF, 64'h1, 1'b1, 64'h0};
        tbl[9]  = '{1'b1, BASE + SPAN,     8'hFF, 64'h5555, 1'b1, 64'h0};
        tbl[10] = '{1'b1, BASE - 64'h8,    8'hFF, 64'h6666, 1'b1, 64'h0};
        tbl[11] = '{1'b0, BASE + 64'h1FF8, 8'h00, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D};
        tbl[12] = '{1'b0, BASE,            8'h00, 64'h0, 1'b0, 64'h0123456789ABCDEF};
        tbl[13] = '{1'b1, BASE + 64'h8,    8'h00, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 64'h0};
        tbl[14] = '{1'b0, BASE + 64'h8,    8'h00, 64'h0, 1'b0, 64'h11223344_BBBBBBBB};
        tbl[15] = '{1'b0, BASE + SPAN,     8'h00, 64'h0, 1'b1, 64'h0};
        tbl[16] = '{1'b1, BASE + 64'h1FFB, 8'h80, 64'h77000000_00000000, 1'b0, 64'h0};
        tbl[17] = '{1'b0, BASE + 64'h1FF8, 8'h00, 64'h0, 1'b0, 64'h77ADBEEF_CAFEF00D};
        for (int i = 0; i < 18; i++) begin
            run_chk($sformatf("table[%0d]", i), 0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd,
                    tbl[i].e, tbl[i].rd);
        end

        // Randomized traffic on stall-0 and stall-3 instances against a word model
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                mdl[d][i] = {$urandom, $urandom};
                run_chk($sformatf("init d%0d w%0d", d, i), d, 1'b1, BASE + 64'(8 * (RGN + i)),
                        8'hFF, mdl[d][i], 1'b0, 64'h0);
            end
            for (int n = 0; n < 30; n++) begin
                w  = 1'($urandom_range(0, 1));
                s  = 8'($urandom);
                wd = {$urandom, $urandom};
                idx = $urandom_range(0, 15);
                case ($urandom_range(0, 9))
                    0: a = BASE - 64'(8 * $urandom_range(1, 4));
                    1: a = BASE + SPAN + 64'($urandom_range(0, 63));
                    2: a = ERRA + 64'($urandom_range(0, 7));
                    default: a = BASE + 64'(8 * (RGN + idx) + $urandom_range(0, 7));
                endcase
                e = ref_err(a);
                if (!e) idx = int'((a - BASE) >> 3) - RGN;
                run_chk($sformatf("rand d%0d #%0d", d, n), d, w, a, s, wd, e,
                        (e || w) ? 64'h0 : mdl[d][idx]);
                if (!e && w) begin
                    for (int b = 0; b < 8; b++) begin
                        if (s[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
                    end
                end
            end
        end

        // Stall 3: gnt exactly on the fourth cycle after req is sampled, single pulse
        check("stall3 proto_err clean", 64'(perr[1]), 64'd0);
        @(negedge clk);
        req[1] = 1'b1; wen[1] = 1'b0; addr[1] = BASE + 64'(8 * RGN); strb[1] = '0; wdata[1] = '0;
        pat = '0; rd_cap = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pat[k] = gnt[1];
            if (gnt[1]) begin
                rd_cap = rdata[1];
                req[1] = 1'b0;
            end
        end
        req[1] = 1'b0;
        $display("txn dut1 RD stall pattern=%b rdata=%h", pat, rd_cap);
        check("stall3 gnt pattern", 64'(pat), 64'h08);
        check("stall3 rdata", rd_cap, mdl[1][0]);

        // Request changes while waiting: captured values win, proto_err set
        @(negedge clk);
        req[1] = 1'b1; wen[1] = 1'b0; addr[1] = BASE + 64'(8 * (RGN + 1));
        @(negedge clk);
        addr[1] = BASE + 64'(8 * (RGN + 2));
        rd_cap = 'x; e = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (gnt[1]) begin
                rd_cap = rdata[1]; e = 1'b1;
                break;
            end
        end
        req[1] = 1'b0;
        $display("txn dut1 RD changed-addr gnt=%b rdata=%h", e, rd_cap);
        check("change gnt seen", 64'(e), 64'd1);
        check("change rdata from captured addr", rd_cap, mdl[1][1]);
        check("change proto_err", 64'(perr[1]), 64'd1);

        // Stall 5: drop req after 2 cycles in WAIT -> abandoned, no gnt, sticky proto_err
        @(negedge clk);
        req[2] = 1'b1; wen[2] = 1'b1; addr[2] = BASE + 64'h1E0; strb[2] = 8'hFF; wdata[2] = 64'h5A5A;
        repeat (2) @(negedge clk);
        req[2] = 1'b0;
        pat = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pat[k] = gnt[2];
        end
        $display("txn dut2 WR dropped gnt pattern=%b proto_err=%b", pat, perr[2]);
        check("drop no gnt", 64'(pat), 64'h0);
        check("drop proto_err", 64'(perr[2]), 64'd1);
        run_chk("after drop write", 2, 1'b1, BASE + 64'h1E8, 8'hFF, 64'hC0FFEE00_12345678, 1'b0, 64'h0);
        run_chk("after drop read", 2, 1'b0, BASE + 64'h1E8, 8'h00, 64'h0, 1'b0, 64'hC0FFEE00_12345678);
        check("drop proto_err held", 64'(perr[2]), 64'd1);

        // Reset during WAIT of a write (stall 3) while the stall-0 instance is granting
        @(negedge clk);
        req[1] = 1'b1; wen[1] = 1'b1; addr[1] = BASE + 64'(8 * (RGN + 3));
        strb[1] = 8'hFF; wdata[1] = ~mdl[1][3];
        @(negedge clk);
        @(negedge clk);
        req[0] = 1'b1; wen[0] = 1'b0; addr[0] = BASE + 64'h8; strb[0] = '0;
        @(negedge clk);
        check("pre-reset gnt dut0", 64'(gnt[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("reset async gnt dut0", 64'(gnt[0]), 64'd0);
        check("reset async gnt dut1", 64'(gnt[1]), 64'd0);
        req[0] = 1'b0; req[1] = 1'b0;
        @(negedge clk);
        check("reset clears proto_err dut1", 64'(perr[1]), 64'd0);
        check("reset clears proto_err dut2", 64'(perr[2]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_chk("after reset read", 1, 1'b0, BASE + 64'(8 * (RGN + 3)), 8'h00, 64'h0, 1'b0, mdl[1][3]);
        run_chk("after reset dut0 read", 0, 1'b0, BASE + 64'h8, 8'h00, 64'h0, 1'b0, 64'h11223344_BBBBBBBB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
